// File: rtl/serial_parity_checker_if.sv
// -----------------------------------------------------------------------------
// serial_parity_checker_if
//
// Word-level valid/ready port of the serial parity checker. One received
// word is presented together with its parity-error flag. The flag belongs
// to the word and means nothing while out_valid is low.
//
// Signals:
//   out_data   [DATA_W-1:0]  received data word (producer -> consumer)
//   out_valid                word and flag are being presented (producer -> consumer)
//   par_err                  parity mismatch for the presented word (producer -> consumer)
//   out_ready                consumer accepts the word this cycle (consumer -> producer)
//
// Modports:
//   master  the checker side, which produces words
//   slave   the consumer side, which accepts words
// -----------------------------------------------------------------------------
interface serial_parity_checker_if #(
    parameter int DATA_W = 8
);

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              par_err;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        output par_err,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  par_err,
        output out_ready
    );

endinterface : serial_parity_checker_if

// File: rtl/serial_parity_checker.sv
// -----------------------------------------------------------------------------
// serial_parity_checker
//
// Receive-side partner of the XOR parity generator. A frame is DATA_W data
// bits sent LSB first, followed by one parity bit. The bits are
// deserialised into a shift register while a running XOR accumulates their
// parity. The completed word and a parity-error flag are then presented on a
// valid/ready port. A saturating counter records how many frames the
// consumer accepted with a parity error.
//
// Frame flow:
//   IDLE   -- waits for start. Serial input is ignored.
//   DATA   -- takes one data bit on each cycle with sin_valid=1.
//   PARITY -- takes the parity bit and presents the word.
//   HOLD   -- holds the word until the consumer handshakes. If start is high
//             on the handshake cycle, the next frame begins immediately.
//
// Parameters:
//   DATA_W  data bits per frame (2..32)
//   ODD     0 = even parity expected, 1 = odd parity expected
//   CNT_W   width of the parity-error counter
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset. Aborts any partial frame.
//   start      frame-start strobe. Honoured in IDLE, or in HOLD on the
//              handshake cycle.
//   sin_valid  qualifies sin
//   sin        serial bit: data LSB first, then the parity bit
//   word       valid/ready word port (out_data, out_valid, par_err, out_ready)
//   err_cnt    saturating count of frames accepted with par_err=1
//   busy       high while a frame is being received (DATA or PARITY)
// -----------------------------------------------------------------------------
module serial_parity_checker #(
    parameter int          DATA_W = 8,
    parameter int unsigned ODD    = 0,
    parameter int          CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sin_valid,
    input  logic                     sin,
    serial_parity_checker_if.master  word,
    output logic [CNT_W-1:0]         err_cnt,
    output logic                     busy
);

    // Bit counter wide enough to index every data bit of a frame.
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    // Seeding the accumulator with ODD makes a correct frame XOR to zero
    // for both parity senses. The error flag is then the final XOR.
    localparam logic ACC_SEED = 1'(ODD);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic              acc;

    // Handshake on the presented word. out_valid is high only in HOLD.
    logic              accept;

    assign accept = word.out_valid & word.out_ready;

    // NOTE: every register here, including the data shift register, uses
    // non-blocking assignment and is cleared by the synchronous reset. The
    // reset exists so that a frame aborted mid-way leaves no stale bits.
    // It also means the outputs come out of reset at a known zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            shreg          <= '0;
            bit_cnt        <= '0;
            acc            <= 1'b0;
            word.out_data  <= '0;
            word.out_valid <= 1'b0;
            word.par_err   <= 1'b0;
            err_cnt        <= '0;
            busy           <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // Serial input is deliberately ignored here, even in the
                    // start cycle. The first data bit arrives in DATA.
                    if (start) begin
                        state   <= S_DATA;
                        shreg   <= '0;
                        bit_cnt <= '0;
                        acc     <= ACC_SEED;
                        busy    <= 1'b1;
                    end
                end

                S_DATA: begin
                    if (sin_valid) begin
                        // LSB-first: each new bit enters at the top and
                        // moves down. After DATA_W shifts, the first bit sits
                        // at bit 0.
                        shreg <= {sin, shreg[DATA_W-1:1]};
                        acc   <= acc ^ sin;
                        if (bit_cnt == LAST_BIT) begin
                            state   <= S_PARITY;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                S_PARITY: begin
                    if (sin_valid) begin
                        word.out_data  <= shreg;
                        word.par_err   <= acc ^ sin;
                        word.out_valid <= 1'b1;
                        state          <= S_HOLD;
                        busy           <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (accept) begin
                        word.out_valid <= 1'b0;
                        if (word.par_err && (err_cnt != CNT_MAX)) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        // A start on the handshake cycle chains straight
                        // into the next frame, with no IDLE cycle between.
                        if (start) begin
                            state   <= S_DATA;
                            shreg   <= '0;
                            bit_cnt <= '0;
                            acc     <= ACC_SEED;
                            busy    <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : serial_parity_checker
